// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one 4-digit hex 7-segment display among three requesters. The
// arbiter gives the display to one requester at a time, for a fixed dwell
// time. Requesters take turns in round-robin order. The turn ends early if
// the owner drops its request.
//
// A turn is:
//   IDLE -> ARB (one cycle, picks the winner) -> HOLD (dwell) -> ARB -> ...
//
// An owner keeps the display for DWELL_MAX+1 HOLD cycles. It is not
// preempted by a request that arrives mid-dwell. At dwell expiry with no
// competing request, the counter wraps and the owner simply keeps the
// display, with no new-grant pulse.
//
// Parameters
//   DWELL_MAX    last dwell count value of a turn (default 1 s at 100 MHz)
//   DWELL_WIDTH  dwell counter width; DWELL_MAX must be < 2**DWELL_WIDTH
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   REQ[2:0]   in   level-sensitive display requests, bit i = requester i
//   VALUE_IN0  in   16-bit value offered by requester 0
//   VALUE_IN1  in   16-bit value offered by requester 1
//   VALUE_IN2  in   16-bit value offered by requester 2
//   VALUE_OUT  out  16-bit value to the display driver
//   GRANT[2:0] out  one-hot display owner, zero = no owner
//   ACTIVE     out  high while a turn is in progress (HOLD)
//   NEW_GRANT  out  one-cycle pulse when GRANT first shows a new owner
//
// Build option
//   DISP_ARB_LATCH_EN  when defined, VALUE_OUT is captured once from the
//                      winner on the ARB edge and frozen for the whole turn,
//                      including across a dwell wrap. When undefined,
//                      VALUE_OUT follows the owner's VALUE_IN every HOLD
//                      cycle, one cycle late.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module display_arbiter #(
  parameter int DWELL_MAX   = 99999999,
  parameter int DWELL_WIDTH = 27
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  REQ,
  input  logic [15:0] VALUE_IN0,
  input  logic [15:0] VALUE_IN1,
  input  logic [15:0] VALUE_IN2,
  output logic [15:0] VALUE_OUT,
  output logic [2:0]  GRANT,
  output logic        ACTIVE,
  output logic        NEW_GRANT
);

  localparam logic [DWELL_WIDTH-1:0] CNT_LAST = DWELL_WIDTH'(DWELL_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [DWELL_WIDTH-1:0] cnt, cnt_nx;
  logic [1:0]             last, last_nx;
  logic [2:0]             grant_nx;
  logic [15:0]            value_nx;
  logic                   active_nx;
  logic                   new_grant_nx;

  // Requester values gathered into a packed array so they can be selected
  // by a one-hot grant vector.
  logic [2:0][15:0] vin;
  assign vin = {VALUE_IN2, VALUE_IN1, VALUE_IN0};

  // AND-OR mux. The select is one-hot, so at most one term is non-zero.
  function automatic logic [15:0] onehot_mux(input logic [2:0]       sel,
                                             input logic [2:0][15:0] data);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      if (sel[i]) r = r | data[i];
    return r;
  endfunction

  // Round-robin pick.
  // The search starts at the requester after the last winner, so the last
  // winner itself is checked last. After reset, last = 2, so requester 0
  // has first priority.
  logic [2:0] win_oh;
  logic [1:0] win_idx;

  always_comb begin : rr_pick
    int idx;
    win_oh  = '0;
    win_idx = '0;
    idx     = 0;
    for (int d = 1; d <= 3; d++) begin
      idx = (int'(last) + d) % 3;
      if (win_oh == '0 && REQ[idx]) begin
        win_oh[idx] = 1'b1;
        win_idx     = 2'(idx);
      end
    end
  end

  // The owner still requesting is the normal case.
  // If another requester is waiting, the dwell expiry hands the display
  // over instead of wrapping the counter.
  logic owner_req;
  logic others_req;
  logic dwell_done;

  assign owner_req  = |(REQ & GRANT);
  assign others_req = |(REQ & ~GRANT);
  assign dwell_done = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_nx      = last;
    grant_nx     = GRANT;
    value_nx     = VALUE_OUT;
    new_grant_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (REQ != 3'b000) state_nx = ARB;
      end

      ARB: begin
        if (win_oh != 3'b000) begin
          state_nx     = HOLD;
          grant_nx     = win_oh;
          last_nx      = win_idx;
          cnt_nx       = '0;
          new_grant_nx = 1'b1;
`ifdef DISP_ARB_LATCH_EN
          value_nx     = onehot_mux(win_oh, vin);
`endif
        end else begin
          // Everyone withdrew while we were arbitrating.
          state_nx = IDLE;
          grant_nx = 3'b000;
        end
      end

      HOLD: begin
`ifndef DISP_ARB_LATCH_EN
        // Follow the owner's value one cycle late, through wraps as well.
        value_nx = onehot_mux(GRANT, vin);
`endif
        if (!owner_req) begin
          // Owner gave up the display. This takes priority over an
          // expiry on the same cycle.
          state_nx = ARB;
          grant_nx = 3'b000;
        end else if (dwell_done) begin
          if (others_req) state_nx = ARB;  // GRANT holds until ARB reloads it
          else            cnt_nx   = '0;   // nobody waiting: same owner goes on
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        grant_nx = 3'b000;
      end
    endcase

    active_nx = (state_nx == HOLD);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 2'd2;
      GRANT     <= 3'b000;
      VALUE_OUT <= 16'h0000;
      ACTIVE    <= 1'b0;
      NEW_GRANT <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last      <= last_nx;
      GRANT     <= grant_nx;
      VALUE_OUT <= value_nx;
      ACTIVE    <= active_nx;
      NEW_GRANT <= new_grant_nx;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter with DWELL_MAX = 9.
// A turn-level reference model tracks who owns the display, how many dwell
// cycles the owner has used, and what the display shows. Directed scenarios
// pin known literal values; a randomized phase follows.
module tb_display_arbiter;

  localparam int DM = 9;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [2:0]  REQ = 3'b000;
  logic [15:0] VALUE_IN0 = 16'h0000;
  logic [15:0] VALUE_IN1 = 16'h0000;
  logic [15:0] VALUE_IN2 = 16'h0000;
  logic [15:0] VALUE_OUT;
  logic [2:0]  GRANT;
  logic        ACTIVE;
  logic        NEW_GRANT;

  display_arbiter #(.DWELL_MAX(DM), .DWELL_WIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ),
    .VALUE_IN0(VALUE_IN0), .VALUE_IN1(VALUE_IN1), .VALUE_IN2(VALUE_IN2),
    .VALUE_OUT(VALUE_OUT), .GRANT(GRANT), .ACTIVE(ACTIVE), .NEW_GRANT(NEW_GRANT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a turn is "owner, dwell used so far".
  // arbitrating = one-cycle pick pending; shown = owner visible on GRANT.
  // ---------------------------------------------------------------------------
  bit          m_busy = 0;         // a turn is in progress (display owned)
  bit          m_arbitrating = 0;  // pick happens on next edge
  int          m_owner = -1;       // -1 = nobody
  int          m_shown = -1;       // requester shown on GRANT
  int          m_prev = 2;         // last winner
  int          m_used = 0;         // dwell cycles already counted
  bit          m_pulse = 0;
  logic [15:0] m_disp = 16'h0000;

  function automatic int pick(input logic [2:0] r, input int prev);
    for (int d = 1; d <= 3; d++)
      if (r[(prev + d) % 3]) return (prev + d) % 3;
    return -1;
  endfunction

  always @(posedge CLK) begin
    logic [15:0] v [3];
    v[0] = VALUE_IN0; v[1] = VALUE_IN1; v[2] = VALUE_IN2;
    m_pulse = 0;
    if (RESET) begin
      m_busy = 0; m_arbitrating = 0; m_owner = -1; m_shown = -1;
      m_prev = 2; m_used = 0; m_disp = 16'h0000;
    end else if (m_arbitrating) begin
      int w;
      w = pick(REQ, m_prev);
      m_arbitrating = 0;
      if (w < 0) begin
        m_shown = -1; m_owner = -1;
      end else begin
        m_owner = w; m_shown = w; m_prev = w; m_used = 0;
        m_busy = 1; m_pulse = 1;
`ifdef DISP_ARB_LATCH_EN
        m_disp = v[w];
`endif
      end
    end else if (m_busy) begin
`ifndef DISP_ARB_LATCH_EN
      m_disp = v[m_owner];
`endif
      if (!REQ[m_owner]) begin
        m_busy = 0; m_arbitrating = 1; m_shown = -1; m_owner = -1;
      end else if (m_used == DM) begin
        if ((REQ & ~(3'b001 << m_owner)) != 0) begin
          m_busy = 0; m_arbitrating = 1;   // owner still shown during pick
        end else m_used = 0;
      end else m_used++;
    end else if (REQ != 0) begin
      m_arbitrating = 1;
    end
  end

  bit chk_en = 0;
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_grant", 32'(GRANT), (m_shown < 0) ? 32'd0 : 32'(3'b001 << m_shown));
      chk("model_value", 32'(VALUE_OUT), 32'(m_disp));
      chk("model_active", 32'(ACTIVE), 32'(m_busy));
      chk("model_new_grant", 32'(NEW_GRANT), 32'(m_pulse));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] seq [$];
    int         pulse_at [$];

    VALUE_IN1 = 16'hAAAA;
    cyc(2);
    chk_en = 1;
    chk("reset_grant", 32'(GRANT), 32'd0);
    chk("reset_value", 32'(VALUE_OUT), 32'h0000);
    chk("reset_active", 32'(ACTIVE), 32'd0);
    chk("reset_new_grant", 32'(NEW_GRANT), 32'd0);

    // First grant latency
    RESET = 0; REQ = 3'b001; VALUE_IN0 = 16'h1234;
    cyc(1);
    chk("lat_grant_still_zero", 32'(GRANT), 32'd0);
    cyc(1);
    chk("lat_grant", 32'(GRANT), 32'h1);
    chk("lat_new_grant", 32'(NEW_GRANT), 32'd1);
    chk("lat_active", 32'(ACTIVE), 32'd1);
    cyc(1);
    chk("lat_value", 32'(VALUE_OUT), 32'h1234);
    chk("lat_pulse_once", 32'(NEW_GRANT), 32'd0);

    // Requester 2 arrives mid-dwell; owner 0 drops at dwell count 4
    REQ = 3'b101; VALUE_IN2 = 16'h0C0C;
    cyc(3);
    chk("no_preempt", 32'(GRANT), 32'h1);
    REQ = 3'b100;
    cyc(1);
    chk("drop_gap_grant", 32'(GRANT), 32'd0);
    chk("drop_gap_value", 32'(VALUE_OUT), 32'h1234);
    cyc(1);
    chk("drop_next_grant", 32'(GRANT), 32'h4);
    chk("drop_next_pulse", 32'(NEW_GRANT), 32'd1);

    // Reset mid-HOLD at dwell count 5 with REQ = 110
    REQ = 3'b110;
    cyc(5);
    RESET = 1;
    cyc(1);
    chk("midrst_grant", 32'(GRANT), 32'd0);
    chk("midrst_value", 32'(VALUE_OUT), 32'h0000);
    chk("midrst_active", 32'(ACTIVE), 32'd0);
    RESET = 0;
    cyc(1);
    chk("midrst_arb_gap", 32'(GRANT), 32'd0);
    cyc(1);
    chk("midrst_regrant", 32'(GRANT), 32'h2);

    // Sole requester 1 through a wrap; value changes mid-turn
    REQ = 3'b010;
    cyc(4);
    VALUE_IN1 = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("wrap_grant", 32'(GRANT), 32'h2);
      chk("wrap_no_pulse", 32'(NEW_GRANT), 32'd0);
    end
`ifdef DISP_ARB_LATCH_EN
    chk("wrap_value", 32'(VALUE_OUT), 32'hAAAA);
`else
    chk("wrap_value", 32'(VALUE_OUT), 32'h5555);
`endif

    // All three requesting: rotation 0 -> 1 -> 2 -> 0
    RESET = 1;
    cyc(1);
    RESET = 0; REQ = 3'b111;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (NEW_GRANT === 1'b1) begin
        seq.push_back(GRANT);
        pulse_at.push_back(i);
      end
    end
    chk("rot_count", 32'(seq.size() >= 4), 32'd1);
    if (seq.size() >= 4) begin
      chk("rot_g0", 32'(seq[0]), 32'h1);
      chk("rot_g1", 32'(seq[1]), 32'h2);
      chk("rot_g2", 32'(seq[2]), 32'h4);
      chk("rot_g3", 32'(seq[3]), 32'h1);
      for (int k = 1; k < 4; k++)
        chk("rot_turn_len", 32'(pulse_at[k] - pulse_at[k-1]), 32'(DM + 2));
    end

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      RESET = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) REQ = 3'($urandom);
      if ($urandom_range(0, 3) == 0) VALUE_IN0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) VALUE_IN1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) VALUE_IN2 = 16'($urandom);
    end
    RESET = 0;
    cyc(2);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
